data_memory_responder: RTL and testbench

Responder end of the core's data-memory interface: accepts the address, write data and read/write strobes issued by the pipeline's MEM stage and returns read data in the same cycle, as the MEM/WB register requires. Holds a word-addressed RAM that is zero-filled by a post-reset initialisation sequence. Detects misaligned and out-of-range accesses into a sticky error record. Keeps saturating access counters for bench and debug visibility.

---
 rtl/data_memory_responder.sv | 157 +++++++++++++++
 tb/tb_data_memory_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder
//
// Responder end of the core's data-memory interface. Loads are answered
// combinationally in the same cycle the strobe and address are presented.
// Stores take effect on the next rising edge. After reset the RAM is cleared
// one word per edge, and the core is served only once that sweep is finished.
// Misaligned or out-of-range accesses are refused. They are recorded in a
// sticky error flag, and the byte address of the first fault is kept.
// Saturating counters track accepted loads and stores.
//
// Ports:
//   clock__i         single clock, all state updates on rising edge
//   reset__i         synchronous, active-high reset
//   memAddr__i       byte address from core
//   memDataWrite__i  store data from core
//   memRead__i       load strobe
//   memWrite__i      store strobe
//   memDataRead__o   load data (combinational), 0 when not a legal load
//   ready__o         high once the post-reset clear has completed
//   error__o         sticky access-error flag
//   errAddr__o       byte address of the first faulting access
//   readCount__o     accepted loads, saturating
//   writeCount__o    accepted stores, saturating
module data_memory_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock__i,
  input  logic                 reset__i,
  input  logic [31:0]          memAddr__i,
  input  logic [31:0]          memDataWrite__i,
  input  logic                 memRead__i,
  input  logic                 memWrite__i,
  output logic [31:0]          memDataRead__o,
  output logic                 ready__o,
  output logic                 error__o,
  output logic [31:0]          errAddr__o,
  output logic [CNT_WIDTH-1:0] readCount__o,
  output logic [CNT_WIDTH-1:0] writeCount__o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                stateReg, stateNext;
  logic [ADDR_WIDTH-1:0] initPtrReg, initPtrNext;
  logic                  errorReg, errorNext;
  logic [31:0]           errAddrReg, errAddrNext;
  logic [CNT_WIDTH-1:0]  readCountReg, readCountNext;
  logic [CNT_WIDTH-1:0]  writeCountReg, writeCountNext;

  // Asynchronous-read RAM: the load must be answered in the cycle it is
  // presented, so the read port cannot be registered.
  logic [31:0] memArray [DEPTH];

  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memWAddr;
  logic [31:0]           memWData;
  logic [31:0]           readData;
  logic [ADDR_WIDTH-1:0] wordIndex;
  logic                  accessLegal;

  assign wordIndex   = memAddr__i[ADDR_WIDTH+1:2];
  assign accessLegal = (memAddr__i[1:0] == 2'b00) &&
                       (memAddr__i[31:ADDR_WIDTH+2] == '0);

  always_comb begin
    stateNext      = stateReg;
    initPtrNext    = initPtrReg;
    errorNext      = errorReg;
    errAddrNext    = errAddrReg;
    readCountNext  = readCountReg;
    writeCountNext = writeCountReg;
    memWe          = 1'b0;
    memWAddr       = wordIndex;
    memWData       = memDataWrite__i;
    readData       = 32'h0;

    case (stateReg)
      INIT: begin
        // Core strobes are ignored while the RAM is being cleared.
        memWe       = 1'b1;
        memWAddr    = initPtrReg;
        memWData    = 32'h0;
        initPtrNext = initPtrReg + ADDR_WIDTH'(1);
        if (&initPtrReg) begin
          stateNext = READY;
        end
      end
      READY: begin
        if (memRead__i || memWrite__i) begin
          if (accessLegal) begin
            if (memRead__i) begin
              // Read before the edge, so a simultaneous store is seen
              // as the old contents in this cycle.
              readData = memArray[wordIndex];
              if (readCountReg != '1) begin
                readCountNext = readCountReg + CNT_WIDTH'(1);
              end
            end
            if (memWrite__i) begin
              memWe = 1'b1;
              if (writeCountReg != '1) begin
                writeCountNext = writeCountReg + CNT_WIDTH'(1);
              end
            end
          end else begin
            errorNext = 1'b1;
            if (!errorReg) begin
              errAddrNext = memAddr__i;
            end
          end
        end
      end
      default: begin
        stateNext = INIT;
      end
    endcase
  end

  always_ff @(posedge clock__i) begin
    if (reset__i) begin
      stateReg      <= INIT;
      initPtrReg    <= '0;
      errorReg      <= 1'b0;
      errAddrReg    <= 32'h0;
      readCountReg  <= '0;
      writeCountReg <= '0;
    end else begin
      stateReg      <= stateNext;
      initPtrReg    <= initPtrNext;
      errorReg      <= errorNext;
      errAddrReg    <= errAddrNext;
      readCountReg  <= readCountNext;
      writeCountReg <= writeCountNext;
    end
  end

  // RAM write port kept free of reset so it maps onto memory resources.
  always_ff @(posedge clock__i) begin
    if (memWe && !reset__i) begin
      memArray[memWAddr] <= memWData;
    end
  end

  assign memDataRead__o = readData;
  assign ready__o       = (stateReg == READY);
  assign error__o       = errorReg;
  assign errAddr__o     = errAddrReg;
  assign readCount__o   = readCountReg;
  assign writeCount__o  = writeCountReg;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder (ADDR_WIDTH=4, CNT_WIDTH=4).
// The driver issues one transaction per cycle and pushes the hand-computed
// expected outputs for that cycle. A monitor pops them at the falling edge.
module tb_data_memory_responder;

  localparam int AW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          rd;
  logic          wr;
  logic [31:0]   rdata;
  logic          ready;
  logic          err;
  logic [31:0]   errAddr;
  logic [CW-1:0] rc;
  logic [CW-1:0] wc;

  always #5 clk = ~clk;

  data_memory_responder #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clock__i       (clk),
    .reset__i       (rst),
    .memAddr__i     (addr),
    .memDataWrite__i(wdata),
    .memRead__i     (rd),
    .memWrite__i    (wr),
    .memDataRead__o (rdata),
    .ready__o       (ready),
    .error__o       (err),
    .errAddr__o     (errAddr),
    .readCount__o   (rc),
    .writeCount__o  (wc)
  );

  typedef struct {
    logic [31:0]   data;
    logic          ready;
    logic          err;
    logic [31:0]   ea;
    logic [CW-1:0] rc;
    logic [CW-1:0] wc;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  logic  txnValid = 1'b0;
  int    checks = 0;
  int    errors = 0;

  // Drive one cycle of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic txn(input string name, input logic [31:0] a, input logic [31:0] d,
                     input logic r, input logic w, input logic [31:0] eData,
                     input logic eReady, input logic eErr, input logic [31:0] eEa,
                     input int eRc, input int eWc);
    exp_t e;
    addr  = a;
    wdata = d;
    rd    = r;
    wr    = w;
    e.data  = eData;
    e.ready = eReady;
    e.err   = eErr;
    e.ea    = eEa;
    e.rc    = CW'(eRc);
    e.wc    = CW'(eWc);
    expQ.push_back(e);
    nameQ.push_back(name);
    txnValid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    txnValid = 1'b0;
    rst   = 1'b1;
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Counts the 16 clearing edges, with strobes that must be ignored, then
  // expects ready in cycle 17 with all status at reset values.
  task automatic initCheck(input string tag);
    for (int k = 1; k <= 16; k++) begin
      if (k == 3)
        txn($sformatf("%s init store ignored", tag), 32'h0, 32'hAAAA5555, 1'b0, 1'b1,
            32'h0, 1'b0, 1'b0, 32'h0, 0, 0);
      else if (k == 5)
        txn($sformatf("%s init misaligned ignored", tag), 32'h3, 32'h0, 1'b1, 1'b0,
            32'h0, 1'b0, 1'b0, 32'h0, 0, 0);
      else if (k == 7)
        txn($sformatf("%s init load gated", tag), 32'h3C, 32'h0, 1'b1, 1'b0,
            32'h0, 1'b0, 1'b0, 32'h0, 0, 0);
      else
        txn($sformatf("%s init cycle %0d", tag, k), 32'h0, 32'h0, 1'b0, 1'b0,
            32'h0, 1'b0, 1'b0, 32'h0, 0, 0);
    end
    txn($sformatf("%s ready cycle 17", tag), 32'h0, 32'h0, 1'b0, 1'b0,
        32'h0, 1'b1, 1'b0, 32'h0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string n;
    if (txnValid) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected: DUT cycle with no queued expectation");
      end else begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        if (rdata !== e.data || ready !== e.ready || err !== e.err ||
            errAddr !== e.ea || rc !== e.rc || wc !== e.wc) begin
          errors++;
          $display("FAIL %s: got data=%h ready=%b err=%b errAddr=%h rc=%0d wc=%0d, expected data=%h ready=%b err=%b errAddr=%h rc=%0d wc=%0d",
                   n, rdata, ready, err, errAddr, rc, wc,
                   e.data, e.ready, e.err, e.ea, e.rc, e.wc);
        end else begin
          $display("ok %s: data=%h ready=%b err=%b errAddr=%h rc=%0d wc=%0d",
                   n, rdata, ready, err, errAddr, rc, wc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Power-up clear, then every word reads 0; readCount saturates at 15.
    initCheck("boot");
    for (int i = 0; i < 16; i++)
      txn($sformatf("load zero w%0d", i), 32'(i * 4), 32'h0, 1'b1, 1'b0,
          32'h0, 1'b1, 1'b0, 32'h0, i, 0);
    txn("read count saturated", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 15, 0);

    // Store then load next cycle.
    doReset();
    initCheck("r2");
    txn("store 0x10",      32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0, 0, 0);
    txn("load 0x10",       32'h10, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 0, 1);
    txn("counts 1/1",      32'h0,  32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1, 1);
    // Load and store together sees old data.
    txn("store 0x8 old",   32'h8,  32'h11111111, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0, 1, 1);
    txn("rd+wr 0x8",       32'h8,  32'h22222222, 1'b1, 1'b1, 32'h11111111, 1'b1, 1'b0, 32'h0, 1, 2);
    txn("load 0x8 new",    32'h8,  32'h0,        1'b1, 1'b0, 32'h22222222, 1'b1, 1'b0, 32'h0, 2, 3);
    txn("counts 3/3",      32'h0,  32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 3, 3);
    txn("reload 0x10",     32'h10, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 3, 3);
    txn("store last word", 32'h3C, 32'hCAFEF00D, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0, 4, 3);
    txn("load last word",  32'h3C, 32'h0,        1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0, 4, 4);
    // Faults: first address kept, stores suppressed, counters frozen.
    txn("misaligned store",32'h6,  32'h12345678, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0, 5, 4);
    txn("misaligned load", 32'h401,32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h6, 5, 4);
    txn("range load 0x40", 32'h40, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h6, 5, 4);
    txn("word1 untouched", 32'h4,  32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h6, 5, 4);
    txn("error sticky",    32'h0,  32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h6, 6, 4);

    // Reset in READY after stores: full restart, prior data cleared.
    doReset();
    initCheck("r3");
    txn("cleared 0x0",     32'h0,  32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 0, 0);
    txn("cleared 0x10",    32'h10, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1, 0);
    txn("cleared 0x3C",    32'h3C, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2, 0);
    txn("high bit load",   32'h80000000, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 3, 0);
    txn("range second",    32'h80000010, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80000000, 3, 0);
    txn("first fault kept",32'h0,  32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80000000, 3, 0);

    // Reset mid-INIT restarts the full clearing sequence.
    doReset();
    for (int k = 1; k <= 5; k++)
      txn($sformatf("r4 partial init %0d", k), 32'h0, 32'h0, 1'b0, 1'b0,
          32'h0, 1'b0, 1'b0, 32'h0, 0, 0);
    doReset();
    initCheck("r5");

    // writeCount saturation; stores still land after saturation.
    for (int i = 0; i < 16; i++)
      txn($sformatf("store w%0d", i), 32'(i * 4), 32'(i + 1), 1'b0, 1'b1,
          32'h0, 1'b1, 1'b0, 32'h0, 0, i);
    txn("store past sat",  32'h0,  32'h99, 1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 32'h0, 0, 15);
    txn("write count sat", 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 0, 15);
    txn("load w0 0x99",    32'h0,  32'h0,  1'b1, 1'b0, 32'h99, 1'b1, 1'b0, 32'h0, 0, 15);
    txn("load w1",         32'h4,  32'h0,  1'b1, 1'b0, 32'h2,  1'b1, 1'b0, 32'h0, 1, 15);
    txn("load w15",        32'h3C, 32'h0,  1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h0, 2, 15);
    txn("final counts",    32'h0,  32'h0,  1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 3, 15);

    txnValid = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
